// File: rtl/mcs_io_master.sv
// MicroBlaze MCS IO bus initiator: one valid/ready command in, one strobed bus
// transaction out, one-cycle response back (with watchdog error on a silent responder).
module mcs_io_master #(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [21:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        io_addr_strobe,
  output logic        io_read_strobe,
  output logic        io_write_strobe,
  output logic [31:0] io_address,
  output logic [3:0]  io_byte_enable,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STB, WAIT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          wr_q;
  logic          acc, ack, tmo;
  logic          cmd_ready_d, stb_d, rsp_valid_d, rsp_err_d;
  logic [31:0]   rsp_data_d;

  assign acc = cmd_valid & cmd_ready;
  // ready wins over the watchdog when both land in the same cycle
  assign ack = (state == WAIT) & io_ready;
  assign tmo = (state == WAIT) & ~io_ready & (cnt == CNT_LIM);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = STB;
      STB:     state_nx = WAIT;
      WAIT:    if (ack || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; STB is only entered on an accept,
  // so the live cmd_wr selects the strobe.
  always_comb begin
    cmd_ready_d = (state_nx == IDLE);
    stb_d       = (state_nx == STB);
    rsp_valid_d = ack | tmo;
    rsp_err_d   = tmo;
    rsp_data_d  = (ack && !wr_q) ? io_read_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_ready       <= 1'b0;
      io_addr_strobe  <= 1'b0;
      io_read_strobe  <= 1'b0;
      io_write_strobe <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      rsp_data        <= '0;
    end else begin
      cmd_ready       <= cmd_ready_d;
      io_addr_strobe  <= stb_d;
      io_read_strobe  <= stb_d & ~cmd_wr;
      io_write_strobe <= stb_d & cmd_wr;
      rsp_valid       <= rsp_valid_d;
      rsp_err         <= rsp_err_d;
      rsp_data        <= rsp_data_d;
    end
  end

  // Bus-side command fields hold from accept until the next accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q           <= 1'b0;
      io_address     <= '0;
      io_byte_enable <= '0;
      io_write_data  <= '0;
    end else if (acc) begin
      wr_q           <= cmd_wr;
      io_address     <= {BRG_BASE[31:24], cmd_addr, 2'b00};
      io_byte_enable <= cmd_be;
      io_write_data  <= cmd_wdata;
    end
  end

  // Watchdog counter: cleared in STB, counts WAIT cycles, saturates.
  always_ff @(posedge clk) begin
    if (!reset_n)                             cnt <= '0;
    else if (state == STB)                    cnt <= '0;
    else if (state == WAIT && cnt != '1)      cnt <= cnt + 1'b1;
  end

endmodule

// File: tb/tb_mcs_io_master.sv
// Directed bench for mcs_io_master (TIMEOUT = 8); inputs driven 1ns after
// posedge, outputs checked in the same window.
module tb_mcs_io_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0] io_address, io_write_data, io_read_data;
  logic [3:0]  io_byte_enable;
  logic        io_ready;

  int n_pass  = 0;
  int n_total = 0;

  mcs_io_master #(.BRG_BASE(32'hc000_0000), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_strb(input string tag, input logic [2:0] exp);
    chk(tag, {29'h0, io_addr_strobe, io_read_strobe, io_write_strobe}, {29'h0, exp});
  endtask

  logic [21:0] bb_addr [4] = '{22'h000100, 22'h000101, 22'h000102, 22'h000103};
  logic [31:0] bb_wdat [4] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
  logic [31:0] bb_exp  [4] = '{32'hC000_0400, 32'hC000_0404, 32'hC000_0408, 32'hC000_040C};

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_be = '0; io_ready = 1'b0; io_read_data = '0;

    // reset state
    tick(); tick();
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk_strb("rst_strobes", 3'b000);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_data",  rsp_data, 32'h0);
    chk("rst_io_address", io_address, 32'h0);
    chk("rst_io_wdata",  io_write_data, 32'h0);
    chk("rst_io_be",     {28'h0, io_byte_enable}, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'h0, cmd_ready}, 32'h1);

    // write with ready tied high
    io_ready = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 22'h00_0004;
    cmd_wdata = 32'hA5A5_0001; cmd_be = 4'hF;
    tick();                                   // accept edge 0 -> cycle 1
    cmd_valid = 1'b0;
    chk_strb("wr_c1_strobes", 3'b101);
    chk("wr_c1_ready", {31'h0, cmd_ready}, 32'h0);
    chk("wr_io_address", io_address, 32'hC000_0010);
    chk("wr_io_wdata", io_write_data, 32'hA5A5_0001);
    chk("wr_io_be", {28'h0, io_byte_enable}, 32'hF);
    tick();                                   // cycle 2
    chk_strb("wr_c2_strobes", 3'b000);
    chk("wr_c2_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    tick();                                   // cycle 3
    chk("wr_c3_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("wr_c3_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("wr_c3_rsp_data", rsp_data, 32'h0);
    chk("wr_c3_ready", {31'h0, cmd_ready}, 32'h1);
    tick();                                   // cycle 4
    chk("wr_c4_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("wr_c4_addr_hold", io_address, 32'hC000_0010);
    io_ready = 1'b0;

    // video read, ready 5 cycles after the strobe
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 22'h20_0001; cmd_be = 4'h3;
    cmd_wdata = 32'hFFFF_FFFF;
    tick();                                   // cycle 1
    cmd_valid = 1'b0;
    chk_strb("rd_c1_strobes", 3'b110);
    chk("rd_io_address", io_address, 32'hC080_0004);
    chk("rd_io_be", {28'h0, io_byte_enable}, 32'h3);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("rd_wait_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    end
    io_ready = 1'b1; io_read_data = 32'h1234_5678;  // cycle 6
    tick();                                   // cycle 7
    io_ready = 1'b0; io_read_data = '0;
    chk("rd_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("rd_rsp_data", rsp_data, 32'h1234_5678);
    chk("rd_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rd_addr_hold", io_address, 32'hC080_0004);

    // timeout, silent responder
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 22'h00_0020;
    tick();                                   // cycle 1
    cmd_valid = 1'b0;
    for (int c = 2; c <= 9; c++) tick();      // cycle 9
    chk("to_c9_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("to_c9_ready", {31'h0, cmd_ready}, 32'h0);
    tick();                                   // cycle 10
    chk("to_c10_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("to_c10_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("to_c10_rsp_data", rsp_data, 32'h0);
    chk("to_c10_ready", {31'h0, cmd_ready}, 32'h1);
    tick();                                   // cycle 11
    chk("to_c11_rsp_valid", {31'h0, rsp_valid}, 32'h0);

    // ready arriving on the last allowed WAIT cycle is a success
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 22'h00_0030;
    tick();
    cmd_valid = 1'b0;
    for (int c = 2; c <= 9; c++) tick();      // cycle 9, counter at limit
    io_ready = 1'b1; io_read_data = 32'h0BAD_F00D;
    tick();                                   // cycle 10
    io_ready = 1'b0;
    chk("lim_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("lim_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("lim_rsp_data", rsp_data, 32'h0BAD_F00D);

    // reset pulse during WAIT
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 22'h00_0040; cmd_wdata = 32'h5555_AAAA;
    tick();
    cmd_valid = 1'b0;
    for (int c = 2; c <= 5; c++) tick();      // cycle 5, 4th WAIT cycle
    reset_n = 1'b0;
    tick();                                   // cycle 6
    reset_n = 1'b1;
    chk_strb("mid_rst_strobes", 3'b000);
    chk("mid_rst_ready", {31'h0, cmd_ready}, 32'h0);
    chk("mid_rst_io_address", io_address, 32'h0);
    chk("mid_rst_io_wdata", io_write_data, 32'h0);
    tick();                                   // cycle 7
    chk("mid_rst_ready_back", {31'h0, cmd_ready}, 32'h1);
    io_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("mid_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
      tick();
    end
    io_ready = 1'b0;
    chk("mid_rst_no_rsp_end", {31'h0, rsp_valid}, 32'h0);

    // cmd_valid held through a busy read, then a stray ready in IDLE
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 22'h00_0010; cmd_be = 4'hC;
    tick();                                   // accept, cycle 1
    for (int c = 1; c <= 3; c++) begin
      chk("hold_busy_ready", {31'h0, cmd_ready}, 32'h0);
      if (c < 3) tick();
    end
    io_ready = 1'b1; io_read_data = 32'hDEAD_BEEF;  // cycle 3
    tick();                                   // cycle 4
    io_ready = 1'b0; cmd_valid = 1'b0;
    chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("hold_rsp_data", rsp_data, 32'hDEAD_BEEF);
    tick();                                   // cycle 5
    chk_strb("hold_no_reaccept", 3'b000);
    chk("hold_idle_ready", {31'h0, cmd_ready}, 32'h1);
    io_ready = 1'b1;
    tick();                                   // cycle 6
    io_ready = 1'b0;
    chk("stray_rdy_no_rsp", {31'h0, rsp_valid}, 32'h0);
    tick();
    chk("stray_rdy_no_rsp2", {31'h0, rsp_valid}, 32'h0);
    chk("stray_rdy_ready", {31'h0, cmd_ready}, 32'h1);

    // four back-to-back writes, ready tied high
    io_ready = 1'b1; cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      cmd_addr = bb_addr[i]; cmd_wdata = bb_wdat[i];
      chk("bb_ready_at_accept", {31'h0, cmd_ready}, 32'h1);
      tick();                                 // accept at cycle 3*i
      chk_strb("bb_strobes", 3'b101);
      chk("bb_io_address", io_address, bb_exp[i]);
      chk("bb_io_wdata", io_write_data, bb_wdat[i]);
      tick();
      chk("bb_busy", {31'h0, cmd_ready}, 32'h0);
      tick();
      chk("bb_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    end
    cmd_valid = 1'b0; io_ready = 1'b0;
    tick();
    chk("bb_last_addr_hold", io_address, 32'hC000_040C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
